square_root_unpack: RTL

Upstream operand-preparation stage for the double-precision square-root path. It accepts an IEEE-754 binary64 operand over a valid/ready handshake and resolves special cases. Subnormal mantissas are normalised sequentially, one bit per cycle. For ordinary operands it emits the 106-bit radicand, whose 53-bit integer root has its hidden bit at bit 52, together with the biased result exponent and sign. The downstream stage consumes the radicand and takes root bits [51:0] as the result mantissa.

---
 rtl/square_root_pkg.sv | 35 +++
 rtl/square_root_classify.sv | 31 +++
 rtl/square_root_unpack.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/square_root_pkg.sv
// Shared constants, types and radicand helpers for the binary64 square-root unpack stage.
package square_root_pkg;

  localparam int unsigned BINARY_SIZE      = 106;
  localparam int unsigned HALF_BINARY_SIZE = 53;
  localparam int unsigned MANTISSA_SIZE    = 52;
  localparam int unsigned EXP_SIZE         = 11;
  localparam int          EXP_BIAS         = 1023;

  localparam logic [63:0] CANON_QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] POS_INF    = 64'h7FF0_0000_0000_0000;

  typedef enum logic [1:0] {IDLE, NORM, OUT} state_t;

  typedef struct packed {
    logic                     sign;
    logic [EXP_SIZE-1:0]      exp;
    logic [MANTISSA_SIZE-1:0] frac;
  } binary64_t;

  // An odd exponent is made even by folding one extra factor of two into the radicand.
  function automatic logic [BINARY_SIZE-1:0] make_radicand(
    input logic [HALF_BINARY_SIZE-1:0] m,
    input logic                        odd
  );
    return odd ? {m, {(BINARY_SIZE-HALF_BINARY_SIZE){1'b0}}}
               : {1'b0, m, {MANTISSA_SIZE{1'b0}}};
  endfunction

  // floor(E/2) equals (E-1)/2 for odd E, so one arithmetic shift covers both parities.
  function automatic logic [EXP_SIZE-1:0] make_exp(input logic signed [11:0] e);
    return EXP_SIZE'((e >>> 1) + EXP_BIAS);
  endfunction

endpackage

// File: rtl/square_root_classify.sv
// Combinational classification of a binary64 operand into IEEE-754 categories.
module square_root_classify
  import square_root_pkg::*;
(
  input  logic [63:0] op,
  output logic        is_zero,
  output logic        is_normal,
  output logic        is_subnormal,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_neg
);

  binary64_t fields;
  logic      exp_zero;
  logic      exp_max;
  logic      frac_zero;

  assign fields    = op;
  assign exp_zero  = ~|fields.exp;
  assign exp_max   = &fields.exp;
  assign frac_zero = ~|fields.frac;

  assign is_zero      = exp_zero & frac_zero;
  assign is_subnormal = exp_zero & ~frac_zero;
  assign is_normal    = ~exp_zero & ~exp_max;
  assign is_inf       = exp_max & frac_zero;
  assign is_nan       = exp_max & ~frac_zero;
  assign is_neg       = fields.sign;

endmodule

// File: rtl/square_root_unpack.sv
// Operand-preparation stage for double-precision sqrt: special-case resolution,
// sequential subnormal normalisation and radicand formation.
// Build option: SQRT_UNPACK_FTZ_EN flushes positive subnormals to +0 (no NORM state).
module square_root_unpack
  import square_root_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BINARY_SIZE-1:0] out_radicand,
  output logic [EXP_SIZE-1:0]    out_exp,
  output logic                   out_sign,
  output logic                   out_special,
  output logic [63:0]            out_special_value
);

  state_t state, state_next;

  logic [BINARY_SIZE-1:0] radicand_next;
  logic [EXP_SIZE-1:0]    exp_next;
  logic                   sign_next;
  logic                   special_next;
  logic [63:0]            special_value_next;

  logic is_zero, is_normal, is_subnormal, is_inf, is_nan, is_neg;

  binary64_t        op;
  logic signed [11:0] e_norm;

  assign op     = in_op;
  assign e_norm = 12'($signed({1'b0, op.exp}) - EXP_BIAS);

`ifndef SQRT_UNPACK_FTZ_EN
  logic [HALF_BINARY_SIZE-1:0] m, m_next;
  logic signed [11:0]          e, e_next;
`endif

  square_root_classify u_classify (
    .op           (in_op),
    .is_zero      (is_zero),
    .is_normal    (is_normal),
    .is_subnormal (is_subnormal),
    .is_inf       (is_inf),
    .is_nan       (is_nan),
    .is_neg       (is_neg)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  always_comb begin
    state_next         = state;
    radicand_next      = out_radicand;
    exp_next           = out_exp;
    sign_next          = out_sign;
    special_next       = out_special;
    special_value_next = out_special_value;
`ifndef SQRT_UNPACK_FTZ_EN
    m_next             = m;
    e_next             = e;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next         = OUT;
          radicand_next      = '0;
          exp_next           = '0;
          special_next       = 1'b1;
          special_value_next = '0;
          if (is_nan) begin
            special_value_next = CANON_QNAN;
          end else if (is_zero) begin
            special_value_next = in_op;
          end else if (is_neg) begin
            special_value_next = CANON_QNAN;
          end else if (is_inf) begin
            special_value_next = POS_INF;
          end else if (is_normal) begin
            special_next  = 1'b0;
            radicand_next = make_radicand({1'b1, op.frac}, e_norm[0]);
            exp_next      = make_exp(e_norm);
          end else if (is_subnormal) begin
`ifndef SQRT_UNPACK_FTZ_EN
            special_next = 1'b0;
            m_next       = {1'b0, op.frac};
            e_next       = -12'sd1022;
            state_next   = NORM;
`endif
          end
          sign_next = special_next & special_value_next[63];
        end
      end
`ifndef SQRT_UNPACK_FTZ_EN
      NORM: begin
        m_next = {m[HALF_BINARY_SIZE-2:0], 1'b0};
        e_next = e - 12'sd1;
        // The leading one reaches the hidden-bit position with this shift.
        if (m[MANTISSA_SIZE-1]) begin
          state_next    = OUT;
          radicand_next = make_radicand(m_next, e_next[0]);
          exp_next      = make_exp(e_next);
        end
      end
`endif
      OUT: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      out_radicand      <= '0;
      out_exp           <= '0;
      out_sign          <= 1'b0;
      out_special       <= 1'b0;
      out_special_value <= '0;
`ifndef SQRT_UNPACK_FTZ_EN
      m                 <= '0;
      e                 <= '0;
`endif
    end else begin
      state             <= state_next;
      out_radicand      <= radicand_next;
      out_exp           <= exp_next;
      out_sign          <= sign_next;
      out_special       <= special_next;
      out_special_value <= special_value_next;
`ifndef SQRT_UNPACK_FTZ_EN
      m                 <= m_next;
      e                 <= e_next;
`endif
    end
  end

endmodule
